// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared field widths, class indices, capture states and the word classifier
package fp_pkg;

    localparam int WORD_W = 32;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_MIN = 8'h00;

    localparam int CLS_NAN    = 3;
    localparam int CLS_INF    = 2;
    localparam int CLS_ZERO   = 1;
    localparam int CLS_DENORM = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SECOND = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Sign bit deliberately ignored: -0 is zero, -inf is inf.
    function automatic logic [3:0] fp_classify(input logic [WORD_W-1:0] w);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic [3:0]        c;
        e = w[WORD_W-2 -: EXP_W];
        m = w[MANT_W-1:0];
        c = '0;
        c[CLS_NAN]    = (e == EXP_MAX) && (m != '0);
        c[CLS_INF]    = (e == EXP_MAX) && (m == '0);
        c[CLS_ZERO]   = (e == EXP_MIN) && (m == '0);
        c[CLS_DENORM] = (e == EXP_MIN) && (m != '0);
        return c;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - first-word-fall-through FIFO; reads zero while empty
module pair_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    // When full, a same-edge pop frees the slot the write lands in.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_count = r_count;
    assign o_rdata = (r_count != '0) ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// rtl/fp_result_collector.sv - pairs dual-multiplier results into a FIFO; FP_RES_CLASSIFY_EN adds class flags
module fp_result_collector
    import fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_done,
    input  logic [31:0]            in_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_res1,
    output logic [31:0]            out_res2,
    output logic [3:0]             out_cls1,
    output logic [3:0]             out_cls2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   proto_err,
    input  logic                   clr_err
);
`ifdef FP_RES_CLASSIFY_EN
    localparam int ENTRY_W = 2*WORD_W + 8;
`else
    localparam int ENTRY_W = 2*WORD_W;
`endif

    state_t              r_state;
    logic [WORD_W-1:0]   r_hold;
    logic                r_overflow;
    logic                r_proto_err;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_drop;
    logic                w_proto_set;
    logic [ENTRY_W-1:0]  w_wdata;
    logic [ENTRY_W-1:0]  w_rdata;

    assign w_push      = (r_state == ST_SECOND) && in_done;
    assign w_pop       = out_valid && out_ready;
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_proto_set = ((r_state == ST_SECOND) && !in_done) ||
                         ((r_state == ST_DRAIN)  &&  in_done);

`ifdef FP_RES_CLASSIFY_EN
    assign w_wdata  = {fp_classify(r_hold), fp_classify(in_res), r_hold, in_res};
    assign out_cls1 = w_rdata[ENTRY_W-1 -: 4];
    assign out_cls2 = w_rdata[ENTRY_W-5 -: 4];
`else
    assign w_wdata  = {r_hold, in_res};
    assign out_cls1 = 4'b0000;
    assign out_cls2 = 4'b0000;
`endif
    assign out_res1  = w_rdata[2*WORD_W-1 -: WORD_W];
    assign out_res2  = w_rdata[WORD_W-1:0];
    assign out_valid = (count != '0);
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

    pair_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (count),
        .o_full  (w_full)
    );

    // Sticky flags: a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_done) begin
                        r_hold  <= in_res;
                        r_state <= ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (in_done) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_hold  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!in_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end else if (clr_err) begin
                r_proto_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_result_collector.sv
// tb/tb_fp_result_collector.sv - randomized and directed bench with a queue-based reference model
module tb_fp_result_collector;

    localparam int DEPTH = 4;
`ifdef FP_RES_CLASSIFY_EN
    localparam bit CLS_ON = 1'b1;
`else
    localparam bit CLS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_done;
    logic [31:0] in_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res1;
    logic [31:0] out_res2;
    logic [3:0]  out_cls1;
    logic [3:0]  out_cls2;
    logic [2:0]  count;
    logic        overflow;
    logic        proto_err;
    logic        clr_err;

    fp_result_collector #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_done   (in_done),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res1  (out_res1),
        .out_res2  (out_res2),
        .out_cls1  (out_cls1),
        .out_cls2  (out_cls2),
        .count     (count),
        .overflow  (overflow),
        .proto_err (proto_err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] m_q[$];
    int          m_run;
    logic [31:0] m_hold;
    bit          m_ov;
    bit          m_pe;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_cls(input logic [31:0] w);
        int e;
        int m;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0, e == 0 && m != 0};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_run  = 0;
        m_hold = '0;
        m_ov   = 0;
        m_pe   = 0;
    endtask

    // The model tracks the length of the current in_done run instead of a state machine.
    task automatic model_edge(input bit d, input logic [31:0] r, input bit rdy, input bit clr);
        int  sz;
        bit  pop;
        bit  push;
        bit  perr;
        bit  ovs;
        sz   = m_q.size();
        pop  = (sz != 0) && rdy;
        push = d && (m_run == 1);
        perr = (!d && m_run == 1) || (d && m_run >= 2);
        ovs  = 0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (sz == DEPTH && !pop) ovs = 1;
            else m_q.push_back({m_hold, r});
        end
        if (d && m_run == 0) m_hold = r;
        m_run = d ? m_run + 1 : 0;
        m_ov = ovs ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_pe = perr ? 1'b1 : (clr ? 1'b0 : m_pe);
    endtask

    task automatic cmp_model();
        logic [63:0] h;
        logic [3:0]  c1;
        logic [3:0]  c2;
        h  = (m_q.size() != 0) ? m_q[0] : 64'd0;
        c1 = (CLS_ON && m_q.size() != 0) ? ref_cls(h[63:32]) : 4'd0;
        c2 = (CLS_ON && m_q.size() != 0) ? ref_cls(h[31:0])  : 4'd0;
        chk("valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("res1", 64'(out_res1), 64'(h[63:32]));
        chk("res2", 64'(out_res2), 64'(h[31:0]));
        chk("cls1", 64'(out_cls1), 64'(c1));
        chk("cls2", 64'(out_cls2), 64'(c2));
        chk("overflow", 64'(overflow), 64'(m_ov));
        chk("proto_err", 64'(proto_err), 64'(m_pe));
    endtask

    task automatic cyc(input bit d, input logic [31:0] r, input bit rdy, input bit clr);
        in_done   = d;
        in_res    = r;
        out_ready = rdy;
        clr_err   = clr;
        @(posedge clk);
        model_edge(d, r, rdy, clr);
        #1;
        cmp_model();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 3);
        if (sel == 0) w[30:23] = 8'hFF;
        if (sel == 1) w[30:23] = 8'h00;
        if ($urandom_range(0, 3) == 0) w[22:0] = '0;
        return w;
    endfunction

    logic [63:0] pv [6];

    initial begin
        in_done   = 0;
        in_res    = '0;
        out_ready = 0;
        clr_err   = 0;
        rst       = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_res1", 64'(out_res1), 64'd0);
        chk("rst_flags", 64'({overflow, proto_err}), 64'd0);
        rst = 0;

        // single pair
        cyc(1, 32'h3F800000, 0, 0);
        cyc(1, 32'h40000000, 0, 0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_res1", 64'(out_res1), 64'h3F800000);
        chk("single_res2", 64'(out_res2), 64'h40000000);
        chk("single_cls", 64'({out_cls1, out_cls2}), 64'd0);
        chk("single_count", 64'(count), 64'd1);
        cyc(0, 0, 1, 0);

        // class flags
        cyc(1, 32'h7FC00000, 0, 0);
        cyc(1, 32'h00000001, 0, 0);
        chk("cls_nan", 64'(out_cls1), CLS_ON ? 64'b1000 : 64'b0000);
        chk("cls_denorm", 64'(out_cls2), CLS_ON ? 64'b0001 : 64'b0000);
        cyc(0, 0, 1, 0);
        cyc(1, 32'hFF800000, 0, 0);
        cyc(1, 32'h80000000, 0, 0);
        chk("cls_inf", 64'(out_cls1), CLS_ON ? 64'b0100 : 64'b0000);
        chk("cls_zero", 64'(out_cls2), CLS_ON ? 64'b0010 : 64'b0000);
        cyc(0, 0, 1, 0);

        // overflow
        for (int i = 0; i < 6; i++) pv[i] = {32'h41000000 + 32'(i), 32'h42000000 + 32'(i)};
        for (int i = 1; i <= 5; i++) begin
            cyc(1, pv[i][63:32], 0, 0);
            cyc(1, pv[i][31:0], 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", 64'({out_res1, out_res2}), pv[1]);
        cyc(0, 0, 0, 1);
        chk("ovf_clr", 64'(overflow), 64'd0);
        repeat (4) cyc(0, 0, 1, 0);
        chk("ovf_empty", 64'(count), 64'd0);

        // full with simultaneous pop
        for (int i = 1; i <= 4; i++) begin
            cyc(1, pv[i][63:32], 0, 0);
            cyc(1, pv[i][31:0], 0, 0);
            cyc(0, 0, 0, 0);
        end
        cyc(1, pv[5][63:32], 0, 0);
        cyc(1, pv[5][31:0], 1, 0);
        chk("fullpop_count", 64'(count), 64'd4);
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        for (int i = 2; i <= 5; i++) begin
            chk("fullpop_order", 64'({out_res1, out_res2}), pv[i]);
            cyc(0, 0, 1, 0);
        end
        chk("fullpop_empty", 64'(count), 64'd0);

        // protocol errors; set wins over a same-cycle clear
        cyc(1, 32'h11111111, 0, 0);
        cyc(0, 0, 0, 1);
        chk("perr_short", 64'(proto_err), 64'd1);
        chk("perr_short_count", 64'(count), 64'd0);
        cyc(0, 0, 0, 1);
        cyc(1, 32'hAAAA0001, 0, 0);
        cyc(1, 32'hAAAA0002, 0, 0);
        cyc(1, 32'hAAAA0003, 0, 0);
        cyc(0, 0, 0, 0);
        chk("perr_long", 64'(proto_err), 64'd1);
        chk("perr_long_count", 64'(count), 64'd1);
        chk("perr_long_head", 64'({out_res1, out_res2}), 64'hAAAA0001_AAAA0002);
        cyc(0, 0, 1, 1);

        // reset mid-pair
        cyc(1, 32'hDEAD0001, 0, 0);
        in_done = 0;
        #2 rst = 1;
        #2 rst = 0;
        model_reset();
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        cyc(0, 0, 0, 0);
        chk("midrst_nopush", 64'(count), 64'd0);
        chk("midrst_perr", 64'(proto_err), 64'd0);
        cyc(1, 32'h3F000000, 0, 0);
        cyc(1, 32'h3E800000, 0, 0);
        chk("midrst_pair", 64'({out_res1, out_res2}), 64'h3F000000_3E800000);
        cyc(0, 0, 1, 0);

        // randomized traffic
        for (int b = 0; b < 150; b++) begin
            int rl;
            int sel;
            int bias;
            sel  = $urandom_range(0, 9);
            rl   = (sel == 0) ? 1 : ((sel == 1) ? 3 : 2);
            bias = (b % 40 < 20) ? 20 : 70;
            for (int i = 0; i < rl; i++)
                cyc(1, rand_word(), $urandom_range(0, 99) < bias, $urandom_range(0, 9) == 0);
            for (int g = 0; g < $urandom_range(1, 3); g++)
                cyc(0, $urandom, $urandom_range(0, 99) < bias, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pair-FIFO depth in entries; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_done, input, 1 bit: upstream dual-multiplier done; high for exactly 2 cycles per result pair.
REQ-005 SHALL have port in_res, input, 32 bits: upstream result; IEEE754 single; first done cycle carries res1, second carries res2.
REQ-006 SHALL have port out_valid, output, 1 bit: head pair available.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts head pair.
REQ-008 SHALL have ports out_res1 and out_res2, output, 32 bits each: head pair.
REQ-009 SHALL have ports out_cls1 and out_cls2, output, 4 bits each: head pair class flags {nan, inf, zero, denorm}.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-011 SHALL have ports overflow and proto_err, output, 1 bit each: sticky error flags.
REQ-012 SHALL have port clr_err, input, 1 bit: synchronous clear of both sticky flags.

Function
REQ-013 SHALL implement capture FSM with states ST_IDLE, ST_SECOND, ST_DRAIN.
REQ-014 In ST_IDLE with in_done=1, SHALL latch in_res into hold register and move to ST_SECOND.
REQ-015 In ST_SECOND with in_done=1, SHALL push {hold, in_res} at that edge and move to ST_DRAIN.
REQ-016 In ST_SECOND with in_done=0, SHALL discard hold, set proto_err, and return to ST_IDLE.
REQ-017 In ST_DRAIN, in_done=0 SHALL return to ST_IDLE; in_done=1 SHALL set proto_err and stay in ST_DRAIN with no capture.
REQ-018 A pushed pair SHALL appear on out_valid/out_res* the cycle after the push edge (first-word-fall-through).
REQ-019 out_valid SHALL equal (count != 0); pop SHALL occur on out_valid && out_ready at the clock edge.
REQ-020 Push when count==DEPTH without a same-cycle pop SHALL drop the pair and set overflow; FIFO contents SHALL remain unchanged.
REQ-021 Push and pop in the same cycle when full SHALL both succeed, with count unchanged.
REQ-022 Push and pop in the same cycle when count==1 SHALL present the new pair next cycle, with count unchanged at 1.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Class rule per word: nan = exp==0xFF and mant!=0; inf = exp==0xFF and mant==0; zero = exp==0 and mant==0; denorm = exp==0 and mant!=0; computed at push and stored; sign ignored.
REQ-025 Sticky flag set and clr_err in the same cycle: set SHALL win.

Reset
REQ-026 rst SHALL asynchronously force: FSM to ST_IDLE, pointers and count to 0, out_valid to 0, overflow and proto_err to 0, hold to 0.
REQ-027 out_res*/out_cls* SHALL read 0 while count==0 after reset.
REQ-028 rst asserted while in ST_SECOND SHALL discard the partial pair, with no push after release.

Configuration
REQ-029 Macro FP_RES_CLASSIFY_EN defined: class logic and FIFO class storage SHALL be present, with out_cls* per REQ-024.
REQ-030 Macro FP_RES_CLASSIFY_EN undefined: out_cls1 and out_cls2 SHALL be tied to 4'b0000, with no class storage; all other behaviour identical.

Structure
REQ-031 Shared package fp_pkg SHALL hold: field widths (EXP_W=8, MANT_W=23), exponent constants 8'hFF/8'h00, class bit indices CLS_NAN=3, CLS_INF=2, CLS_ZERO=1, CLS_DENORM=0, and FSM state encodings.
REQ-032 FIFO SHALL be a sub-module pair_fifo (parameters DEPTH and data width), instantiated once.

Verification
REQ-033 Bench SHALL cover a single pair: in_done=1 for 2 cycles with in_res=0x3F800000 then 0x40000000 -> next cycle out_valid=1, out_res1=0x3F800000, out_res2=0x40000000, cls=0/0, count=1.
REQ-034 Bench SHALL cover classes: pair 0x7FC00000, 0x00000001 -> out_cls1=4'b1000, out_cls2=4'b0001; pair 0xFF800000, 0x80000000 -> 4'b0100, 4'b0010; macro undefined -> all 0.
REQ-035 Bench SHALL cover overflow: out_ready=0, 5 pairs with DEPTH=4 -> count=4, overflow=1, head is pair 1; clr_err -> overflow=0.
REQ-036 Bench SHALL cover full with simultaneous pop: count=4 and out_ready=1 on the push edge -> count stays 4, overflow=0, pairs 2..5 drain in order.
REQ-037 Bench SHALL cover protocol errors: in_done high 1 cycle -> proto_err=1, count unchanged; in_done high 3 cycles -> one pair pushed, proto_err=1.
REQ-038 Bench SHALL cover reset mid-pair: rst pulse after first done cycle -> count=0, no push, next clean pair captured correctly.
